// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronised input, mid-bit sampling, one-cycle
// DV / frame-error pulses, break hold-off after a low stop bit.
`timescale 1ns/1ps
module uart_rx #(
    parameter int  CLKS_PER_BIT = 5208,
    localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1
) (
    input  logic       i_Clock,
    input  logic       i_Reset_n,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Frame_Err,
    output logic       o_Busy
);

    localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t           state, state_next;
    logic [1:0]       sync;
    logic             rx_s;
    logic [CNT_W-1:0] timer, timer_next;
    logic [2:0]       idx, idx_next;
    logic [7:0]       shift, shift_next;
    logic [7:0]       rx_byte, rx_byte_next;
    logic             dv, dv_next;
    logic             ferr, ferr_next;

    assign rx_s = sync[1];

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            sync    <= '1;
            state   <= IDLE;
            timer   <= '0;
            idx     <= '0;
            shift   <= '0;
            rx_byte <= '0;
            dv      <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            sync    <= {sync[0], i_Rx_Serial};
            state   <= state_next;
            timer   <= timer_next;
            idx     <= idx_next;
            shift   <= shift_next;
            rx_byte <= rx_byte_next;
            dv      <= dv_next;
            ferr    <= ferr_next;
        end
    end

    always_comb begin
        state_next   = state;
        timer_next   = timer;
        idx_next     = idx;
        shift_next   = shift;
        rx_byte_next = rx_byte;
        dv_next      = 1'b0;
        ferr_next    = 1'b0;
        case (state)
            IDLE: begin
                timer_next = '0;
                idx_next   = '0;
                if (!rx_s) state_next = START;
            end
            START: begin
                // A start bit still high at its midpoint was a glitch.
                if (timer == HALF) begin
                    timer_next = '0;
                    state_next = rx_s ? IDLE : DATA;
                end else begin
                    timer_next = timer + CNT_W'(1);
                end
            end
            DATA: begin
                if (timer == LAST) begin
                    timer_next      = '0;
                    shift_next[idx] = rx_s;
                    if (idx == 3'd7) state_next = STOP;
                    else             idx_next   = idx + 3'd1;
                end else begin
                    timer_next = timer + CNT_W'(1);
                end
            end
            STOP: begin
                // Leaving at mid-stop lets an immediately following start bit be seen.
                if (timer == LAST) begin
                    timer_next = '0;
                    if (rx_s) begin
                        rx_byte_next = shift;
                        dv_next      = 1'b1;
                        state_next   = IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = BREAK;
                    end
                end else begin
                    timer_next = timer + CNT_W'(1);
                end
            end
            BREAK: begin
                timer_next = '0;
                if (rx_s) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
                idx_next   = '0;
            end
        endcase
    end

    assign o_Rx_DV     = dv;
    assign o_Rx_Byte   = rx_byte;
    assign o_Frame_Err = ferr;
    assign o_Busy      = (state != IDLE);

endmodule
